multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle variant of the team's MIPS-subset CPU. It sequences one shared ALU, one unified instruction/data memory and the register file over FETCH/DECODE/EXEC/MEM/WB.
- Replaces the per-instruction combinational control of the single-cycle core.
- Supports variable-latency memory through a mem_ready handshake.
- Drives all datapath mux selects and write enables. The datapath holds PC, IR, A, B, MDR and ALUOut.

Parameters:
- RESET_STATE, 3'd0, encoding of the state entered on reset (FETCH).

Ports:
- clk  in  1  clock
- reset  in  1  async, active-high
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational in the current cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- pc_source  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=A (rs)
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  2  0=PC, 1=A, 2=shamt
- alu_src_b  out  2  0=B, 1=const 4, 2=ext imm, 3=ext imm<<2
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded, 3=opcode-decoded
- ext_op  out  1  sign-extend immediate
- lu_op  out  1  immediate<<16 (lui)
- illegal  out  1  one-cycle pulse on undecodable op/funct
- state  out  3  current state, for debug

Behaviour:
- Reset is clk (posedge), reset async active-high. On reset, state goes to FETCH immediately.
- All enables (pc_write, ir_write, reg_write, mem_read, mem_write) are forced to 0 while reset is high. Selects are 0.
- Outputs are combinational from state, op, funct, zero and mem_ready. Only the state register is sequential.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - j: pc_write=1, pc_source=2; next FETCH.
  - jal: as j, plus reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4); next FETCH.
  - jr (op 0, funct 0x08): pc_write=1, pc_source=3; next FETCH.
  - jalr (funct 0x09): pc_write=1, pc_source=3, reg_write=1, reg_dst=1, mem_to_reg=2; next FETCH.
  - Illegal: illegal=1; next FETCH; no writes.
  - All other instructions: next EXEC.
- EXEC:
  - R-type: alu_src_a=2 for sll/srl/sra, otherwise 1; alu_src_b=0; alu_op=2; next WB.
  - I-ALU (addi, addiu, andi, ori, slti, sltiu, lui): alu_src_a=1, alu_src_b=2, alu_op=3.
    - ext_op=0 for andi and ori, 1 otherwise.
    - lu_op=1 for lui only.
    - next WB.
  - lw/sw: alu_src_a=1, alu_src_b=2, alu_op=0, ext_op=1; next MEM.
  - beq/bne: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1.
    - beq: pc_write=zero. bne: pc_write=!zero.
    - next FETCH.
- MEM: i_or_d=1.
  - lw: mem_read=1; go to WB on mem_ready.
  - sw: mem_write=1; go to FETCH on mem_ready.
  - Requests are held steady until mem_ready.
- WB: reg_write=1.
  - lw: mem_to_reg=1, reg_dst=0.
  - R-type: reg_dst=1.
  - I-ALU: reg_dst=0.
  - next FETCH.
- Latency with mem_ready=1: j/jal/jr/jalr 2 cycles; beq/bne 3; R/I-ALU 4; sw 4; lw 5. Each cycle of mem_ready low adds one cycle.
- mem_ready outside FETCH and MEM is ignored.
- Unreachable state encodings go to FETCH with no writes asserted.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - Adds output inst_retired[31:0], incremented on each transition into FETCH from any state other than FETCH.
  - Adds output stall_cycles[31:0], incremented each cycle in FETCH or MEM with mem_ready=0.
  - Both counters clear on reset and wrap modulo 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4)
  - opcode and funct constants
  - pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg and alu_op encodings
- Sub-module mc_decode: combinational op/funct to a one-hot instruction class (rtype, shift, ialu, load, store, beq, bne, j, jal, jr, jalr, illegal). The FSM consumes only the class.

Test Plan:
- add (op 0x00, funct 0x20), mem_ready=1: states 0,1,2,4,0. reg_write=1 only in WB with reg_dst=1, mem_to_reg=0. 4 cycles.
- lw (op 0x23), mem_ready low 2 cycles in MEM: MEM lasts 3 cycles with mem_read=1 and i_or_d=1 held. WB has reg_write=1, mem_to_reg=1. 7 cycles total.
- beq (op 0x04): with zero=1, EXEC has pc_write=1, pc_source=1. With zero=0, pc_write=0. bne (op 0x05) gives the inverse. 3 cycles each.
- jal (op 0x03): DECODE has pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. FETCH follows after 2 cycles.
- sw (op 0x2B) with mem_ready=0, reset pulsed during MEM: mem_write drops to 0 in the same cycle and state=0. After release the next FETCH proceeds normally.
- op 0x3F: illegal=1 for exactly one cycle in DECODE, then FETCH. pc_write, reg_write and mem_write stay 0 throughout.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct constants, datapath select codes and the decoded instruction class.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_A     = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WBSEL_ALUOUT = 2'd0;
    localparam logic [1:0] WBSEL_MDR    = 2'd1;
    localparam logic [1:0] WBSEL_PC     = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_OPC   = 2'd3;

    // Exactly one class bit is set; ialu_zext/ialu_lui qualify the ialu class.
    typedef struct packed {
        logic rtype;
        logic shift;
        logic ialu;
        logic load;
        logic store;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
        logic illegal;
        logic ialu_zext;
        logic ialu_lui;
    } inst_class_t;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational op/funct decoder producing the one-hot instruction class
// consumed by the multi-cycle controller FSM.
module mc_decode
    import multicycle_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    output inst_class_t o_class
);

    always_comb begin
        o_class = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_SLL, FN_SRL, FN_SRA: o_class.shift = 1'b1;
                    FN_JR:                  o_class.jr    = 1'b1;
                    FN_JALR:                o_class.jalr  = 1'b1;
                    FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU:        o_class.rtype = 1'b1;
                    default:                o_class.illegal = 1'b1;
                endcase
            end
            OP_J:   o_class.j   = 1'b1;
            OP_JAL: o_class.jal = 1'b1;
            OP_BEQ: o_class.beq = 1'b1;
            OP_BNE: o_class.bne = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: o_class.ialu = 1'b1;
            OP_ANDI, OP_ORI: begin
                o_class.ialu      = 1'b1;
                o_class.ialu_zext = 1'b1;
            end
            OP_LUI: begin
                o_class.ialu     = 1'b1;
                o_class.ialu_lui = 1'b1;
            end
            OP_LW:   o_class.load    = 1'b1;
            OP_SW:   o_class.store   = 1'b1;
            default: o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle MIPS-subset core.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_source,
    output logic        o_i_or_d,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_reg_write,
    output logic [1:0]  o_reg_dst,
    output logic [1:0]  o_mem_to_reg,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic        o_ext_op,
    output logic        o_lu_op,
    output logic        o_illegal,
    output logic [2:0]  o_state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] o_inst_retired,
    output logic [31:0] o_stall_cycles
`endif
);

    state_t      r_state;
    state_t      w_next;
    inst_class_t w_class;

    mc_decode u_decode (
        .i_op    (i_op),
        .i_funct (i_funct),
        .o_class (w_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= state_t'(RESET_STATE);
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_pc_write   = 1'b0;
        o_pc_source  = PCSRC_ALU;
        o_i_or_d     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = DST_RT;
        o_mem_to_reg = WBSEL_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_B;
        o_alu_op     = ALUOP_ADD;
        o_ext_op     = 1'b0;
        o_lu_op      = 1'b0;
        o_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
                w_next      = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures the branch target while the class resolves.
                o_alu_src_b = SRCB_IMM_SH;
                w_next      = S_FETCH;
                if (w_class.j || w_class.jal) begin
                    o_pc_write  = 1'b1;
                    o_pc_source = PCSRC_JUMP;
                end
                if (w_class.jr || w_class.jalr) begin
                    o_pc_write  = 1'b1;
                    o_pc_source = PCSRC_RS;
                end
                if (w_class.jal) begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = DST_RA;
                    o_mem_to_reg = WBSEL_PC;
                end
                if (w_class.jalr) begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = DST_RD;
                    o_mem_to_reg = WBSEL_PC;
                end
                o_illegal = w_class.illegal;
                if (w_class.rtype || w_class.shift || w_class.ialu || w_class.load ||
                    w_class.store || w_class.beq || w_class.bne)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                if (w_class.rtype || w_class.shift) begin
                    o_alu_src_a = w_class.shift ? SRCA_SHAMT : SRCA_A;
                    o_alu_src_b = SRCB_B;
                    o_alu_op    = ALUOP_FUNCT;
                    w_next      = S_WB;
                end else if (w_class.ialu) begin
                    o_alu_src_a = SRCA_A;
                    o_alu_src_b = SRCB_IMM;
                    o_alu_op    = ALUOP_OPC;
                    o_ext_op    = ~w_class.ialu_zext;
                    o_lu_op     = w_class.ialu_lui;
                    w_next      = S_WB;
                end else if (w_class.load || w_class.store) begin
                    o_alu_src_a = SRCA_A;
                    o_alu_src_b = SRCB_IMM;
                    o_alu_op    = ALUOP_ADD;
                    o_ext_op    = 1'b1;
                    w_next      = S_MEM;
                end else if (w_class.beq || w_class.bne) begin
                    o_alu_src_a = SRCA_A;
                    o_alu_src_b = SRCB_B;
                    o_alu_op    = ALUOP_SUB;
                    o_pc_source = PCSRC_ALUOUT;
                    o_pc_write  = w_class.beq ? i_zero : ~i_zero;
                end
            end
            S_MEM: begin
                o_i_or_d = 1'b1;
                w_next   = S_FETCH;
                if (w_class.load) begin
                    o_mem_read = 1'b1;
                    w_next     = i_mem_ready ? S_WB : S_MEM;
                end else if (w_class.store) begin
                    o_mem_write = 1'b1;
                    w_next      = i_mem_ready ? S_FETCH : S_MEM;
                end
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = (w_class.rtype || w_class.shift) ? DST_RD : DST_RT;
                o_mem_to_reg = w_class.load ? WBSEL_MDR : WBSEL_ALUOUT;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset blanks every enable and select, not just the state.
        if (reset) begin
            o_pc_write   = 1'b0;
            o_pc_source  = 2'd0;
            o_i_or_d     = 1'b0;
            o_mem_read   = 1'b0;
            o_mem_write  = 1'b0;
            o_ir_write   = 1'b0;
            o_reg_write  = 1'b0;
            o_reg_dst    = 2'd0;
            o_mem_to_reg = 2'd0;
            o_alu_src_a  = 2'd0;
            o_alu_src_b  = 2'd0;
            o_alu_op     = 2'd0;
            o_ext_op     = 1'b0;
            o_lu_op      = 1'b0;
            o_illegal    = 1'b0;
        end
    end

    assign o_state = r_state;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_inst_retired;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_retired <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (r_state != S_FETCH && w_next == S_FETCH)
                r_inst_retired <= r_inst_retired + 32'd1;
            if ((r_state == S_FETCH || r_state == S_MEM) && !i_mem_ready)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_inst_retired = r_inst_retired;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: builds the expected per-cycle
// control trace of each instruction and compares it against the DUT every cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       lu_op;
        logic       illegal;
    } obs_t;

    typedef enum int {K_R, K_SHIFT, K_IALU, K_LW, K_SW, K_BEQ, K_BNE,
                      K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_e;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       ext_op, lu_op, illegal;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [2:0] state;

    int   n_vec = 0;
    int   n_bad = 0;
    obs_t exp_q[$];

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .i_op         (op),
        .i_funct      (funct),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_pc_write   (pc_write),
        .o_pc_source  (pc_source),
        .o_i_or_d     (i_or_d),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_ir_write   (ir_write),
        .o_reg_write  (reg_write),
        .o_reg_dst    (reg_dst),
        .o_mem_to_reg (mem_to_reg),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_alu_op     (alu_op),
        .o_ext_op     (ext_op),
        .o_lu_op      (lu_op),
        .o_illegal    (illegal),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic kind_e kind_of(input logic [5:0] iop, input logic [5:0] ifn);
        case (iop)
            6'h00: begin
                if (ifn == 6'h00 || ifn == 6'h02 || ifn == 6'h03) return K_SHIFT;
                if (ifn == 6'h08) return K_JR;
                if (ifn == 6'h09) return K_JALR;
                if ((ifn >= 6'h20 && ifn <= 6'h27) || ifn == 6'h2A || ifn == 6'h2B ||
                    ifn == 6'h04 || ifn == 6'h06 || ifn == 6'h07) return K_R;
                return K_ILL;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: return K_IALU;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    // Expected trace: fw stalled FETCH cycles, mw stalled MEM cycles.
    // hold_mem stops the trace after the stalled MEM cycles (no completing cycle).
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                             input int fw, input int mw, input bit hold_mem, output int ncyc);
        obs_t  seq[$];
        logic  mrs[$];
        obs_t  o;
        kind_e k;
        bit    more;
        k = kind_of(iop, ifn);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'd1;
            seq.push_back(o); mrs.push_back(1'b0);
        end
        o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'd1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        seq.push_back(o); mrs.push_back(1'b1);

        o = '0; o.state = 3'd1; o.alu_src_b = 2'd3;
        case (k)
            K_J:    begin o.pc_write = 1'b1; o.pc_source = 2'd2; end
            K_JAL:  begin o.pc_write = 1'b1; o.pc_source = 2'd2; o.reg_write = 1'b1;
                          o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
            K_JR:   begin o.pc_write = 1'b1; o.pc_source = 2'd3; end
            K_JALR: begin o.pc_write = 1'b1; o.pc_source = 2'd3; o.reg_write = 1'b1;
                          o.reg_dst = 2'd1; o.mem_to_reg = 2'd2; end
            K_ILL:  o.illegal = 1'b1;
            default: ;
        endcase
        seq.push_back(o); mrs.push_back(1'($urandom_range(0, 1)));
        more = !(k inside {K_J, K_JAL, K_JR, K_JALR, K_ILL});

        if (more) begin
            o = '0; o.state = 3'd2;
            case (k)
                K_R, K_SHIFT: begin
                    o.alu_src_a = (k == K_SHIFT) ? 2'd2 : 2'd1; o.alu_op = 2'd2;
                end
                K_IALU: begin
                    o.alu_src_a = 2'd1; o.alu_src_b = 2'd2; o.alu_op = 2'd3;
                    o.ext_op = !(iop == 6'h0C || iop == 6'h0D);
                    o.lu_op  = (iop == 6'h0F);
                end
                K_LW, K_SW: begin
                    o.alu_src_a = 2'd1; o.alu_src_b = 2'd2; o.ext_op = 1'b1;
                end
                default: begin
                    o.alu_src_a = 2'd1; o.alu_op = 2'd1; o.pc_source = 2'd1;
                    o.pc_write = (k == K_BEQ) ? iz : !iz;
                end
            endcase
            seq.push_back(o); mrs.push_back(1'($urandom_range(0, 1)));
            more = !(k inside {K_BEQ, K_BNE});
        end

        if (more && (k == K_LW || k == K_SW)) begin
            o = '0; o.state = 3'd3; o.i_or_d = 1'b1;
            o.mem_read = (k == K_LW); o.mem_write = (k == K_SW);
            for (int i = 0; i < mw; i++) begin
                seq.push_back(o); mrs.push_back(1'b0);
            end
            if (!hold_mem) begin
                seq.push_back(o); mrs.push_back(1'b1);
            end
            more = (k == K_LW) && !hold_mem;
        end

        if (more) begin
            o = '0; o.state = 3'd4; o.reg_write = 1'b1;
            o.reg_dst    = (k == K_R || k == K_SHIFT) ? 2'd1 : 2'd0;
            o.mem_to_reg = (k == K_LW) ? 2'd1 : 2'd0;
            seq.push_back(o); mrs.push_back(1'($urandom_range(0, 1)));
        end

        ncyc = seq.size();
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            reset = 1'b0; op = iop; funct = ifn; zero = iz; mem_ready = mrs[i];
            exp_q.push_back(seq[i]);
        end
    endtask

    task automatic reset_cycle();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        exp_q.push_back('0);
    endtask

    // Compare process: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  ext_op, lu_op, illegal};
            chk($sformatf("cycle op=%h fn=%h st=%0d", op, funct, e.state),
                32'(g), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset_cycle();
        reset_cycle();

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, n); chk("len_add", n, 4);
        run_instr(6'h00, 6'h00, 1'b0, 0, 0, 0, n); chk("len_sll", n, 4);
        run_instr(6'h08, 6'h00, 1'b0, 1, 0, 0, n); chk("len_addi_fstall", n, 5);
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0, 0, n);
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0, 0, n);
        run_instr(6'h0F, 6'h00, 1'b0, 0, 0, 0, n);
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 0, n); chk("len_lw_mstall2", n, 7);
        run_instr(6'h23, 6'h00, 1'b0, 0, 0, 0, n); chk("len_lw", n, 5);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 0, n); chk("len_sw", n, 4);
        run_instr(6'h2B, 6'h00, 1'b1, 2, 1, 0, n); chk("len_sw_stalls", n, 7);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0, n); chk("len_beq", n, 3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0, n);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 0, n); chk("len_bne", n, 3);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, 0, n);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0, n); chk("len_j", n, 2);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0, 0, n); chk("len_jal", n, 2);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, 0, n);
        run_instr(6'h00, 6'h09, 1'b0, 0, 0, 0, n);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 0, n); chk("len_illegal_op", n, 2);
        run_instr(6'h00, 6'h01, 1'b0, 0, 0, 0, n);

        // sw stalled in MEM, then reset asserted mid-cycle.
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1, 1, n); chk("len_sw_held", n, 4);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_i_or_d", 32'(i_or_d), 32'd0);
        reset_cycle();
        run_instr(6'h00, 6'h22, 1'b0, 0, 0, 0, n); chk("len_sub_after_rst", n, 4);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
